// File: rtl/vram_pkg.sv
// vram_pkg: shared types and default widths for the video RAM arbiter
package vram_pkg;
    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous write FIFO with a registered full flag
module vram_wr_fifo #(
    parameter int W = 20,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    // full looks at the next count, so a pop while full only frees a slot one cycle later
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full <= count_nxt == CW'(DEPTH);
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between pixel reads (priority) and queued game writes
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter logic ACTIVE_WR = 1'b0,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              blank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [CW-1:0]     fifo_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state, state_nxt;
    logic rd, push, grant, last_pop, empty, full, rd_p1;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0] head_addr, addr_q;
    logic [DATA_W-1:0] head_data, wdata_q;

    vram_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (grant),
        .din     ({wr_addr, wr_data}),
        .head    (head),
        .count   (fifo_count),
        .empty   (empty),
        .full    (full)
    );

    assign {head_addr, head_data} = head;
    assign wr_ready = !full;
    assign push = wr_req && wr_ready;
    // gating with Reset_n keeps the RAM untouched during the reset cycle
    assign rd = rd_req && Reset_n;
    assign grant = Reset_n && !empty && !rd_req && (state == DRAIN || (ACTIVE_WR && state == HOLD));
    assign last_pop = grant && fifo_count == CW'(1) && !push;

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = push ? (blank ? DRAIN : HOLD) : IDLE;
        else if (last_pop) state_nxt = IDLE;
        else state_nxt = blank ? DRAIN : HOLD;
    end

    always_comb begin
        mem_we = grant;
        mem_addr = rd ? rd_addr : grant ? head_addr : addr_q;
        mem_wdata = grant ? head_data : wdata_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            addr_q <= '0;
            wdata_q <= '0;
            rd_p1 <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            addr_q <= mem_addr;
            wdata_q <= mem_wdata;
            rd_p1 <= rd;
            rd_valid <= rd_p1;
            if (rd_p1) rd_data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table plus read/write scoreboards for vram_arbiter with ACTIVE_WR=0 and 1
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic blank = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
    logic [11:0] rd_addr = '0, wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic [7:0] rd_data0, rd_data1, mwd0, mwd1, mrd0, mrd1;
    logic rd_valid0, rd_valid1, wr_ready0, wr_ready1, mwe0, mwe1;
    logic [2:0] cnt0, cnt1;
    logic [11:0] maddr0, maddr1;

    logic [7:0] ram [2][4096];
    wr_entry_t wq [2][$];
    logic [7:0] rq [2][$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic bl, wr, rd;
        logic [11:0] wa, ra;
        logic [7:0] wd;
        logic we, rdy, v;
        logic [2:0] cnt;
        logic [11:0] ma;
    } vec_t;
    vec_t tbl [24];

    always #5 Clk = ~Clk;

    vram_arbiter #(.ACTIVE_WR(1'b0)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .blank(blank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready0),
        .fifo_count(cnt0), .mem_addr(maddr0), .mem_wdata(mwd0), .mem_we(mwe0), .mem_rdata(mrd0)
    );

    vram_arbiter #(.ACTIVE_WR(1'b1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .blank(blank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready1),
        .fifo_count(cnt1), .mem_addr(maddr1), .mem_wdata(mwd1), .mem_we(mwe1), .mem_rdata(mrd1)
    );

    // RAM models: 1-cycle synchronous read, preloaded with addr ^ 0x5A
    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) ram[k][i] = 8'(i) ^ 8'h5A;
        mrd0 = '0;
        mrd1 = '0;
        forever begin
            @(posedge Clk);
            mrd0 <= ram[0][maddr0];
            mrd1 <= ram[1][maddr1];
            if (mwe0) ram[0][maddr0] <= mwd0;
            if (mwe1) ram[1][maddr1] <= mwd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [7:0] rd, input logic we,
                       input logic [11:0] a, input logic [7:0] d, input logic rdy);
        wr_entry_t e;
        if (!Reset_n) begin
            wq[k].delete();
            rq[k].delete();
            return;
        end
        if (v) begin
            chk($sformatf("u%0d read pending", k), 32'(rq[k].size() > 0), 32'(1));
            if (rq[k].size() > 0) chk($sformatf("u%0d rd_data", k), 32'(rd), 32'(rq[k].pop_front()));
        end
        if (we) begin
            chk($sformatf("u%0d write pending", k), 32'(wq[k].size() > 0), 32'(1));
            if (wq[k].size() > 0) begin
                e = wq[k].pop_front();
                chk($sformatf("u%0d write addr/data", k), 32'({a, d}), 32'({e.addr, e.data}));
            end
        end
        if (wr_req && rdy) begin
            e.addr = wr_addr;
            e.data = wr_data;
            wq[k].push_back(e);
        end
        if (rd_req) rq[k].push_back(ram[k][rd_addr]);
    endtask

    always @(negedge Clk) begin
        mon(0, rd_valid0, rd_data0, mwe0, maddr0, mwd0, wr_ready0);
        mon(1, rd_valid1, rd_data1, mwe1, maddr1, mwd1, wr_ready1);
    end

    function automatic vec_t mk(input logic bl, input logic wr, input logic [11:0] wa, input logic [7:0] wd,
                                input logic rd, input logic [11:0] ra, input logic we, input logic [2:0] cnt,
                                input logic rdy, input logic v, input logic [11:0] ma);
        vec_t t;
        t.bl = bl; t.wr = wr; t.wa = wa; t.wd = wd; t.rd = rd; t.ra = ra;
        t.we = we; t.cnt = cnt; t.rdy = rdy; t.v = v; t.ma = ma;
        return t;
    endfunction

    task automatic drv(input logic bl, input logic wr, input logic [11:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [11:0] ra);
        @(posedge Clk);
        #1;
        blank = bl; wr_req = wr; wr_addr = wa; wr_data = wd; rd_req = rd; rd_addr = ra;
        @(negedge Clk);
    endtask

    initial begin
        logic [7:0] e_rd, e_we, e_v;
        // hold during active video, backpressure when full, read priority over drain (expectations for u0)
        tbl[0]  = mk(O, I, 12'h123, 8'hAB, O, 12'h000, O, 3'd0, I, O, 12'h000);
        tbl[1]  = mk(O, O, 12'h000, 8'h00, O, 12'h000, O, 3'd1, I, O, 12'h000);
        tbl[2]  = mk(I, O, 12'h000, 8'h00, O, 12'h000, O, 3'd1, I, O, 12'h000);
        tbl[3]  = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd1, I, O, 12'h123);
        tbl[4]  = mk(I, O, 12'h000, 8'h00, O, 12'h000, O, 3'd0, I, O, 12'h123);
        tbl[5]  = mk(O, I, 12'h200, 8'h01, O, 12'h000, O, 3'd0, I, O, 12'h123);
        tbl[6]  = mk(O, I, 12'h201, 8'h02, O, 12'h000, O, 3'd1, I, O, 12'h123);
        tbl[7]  = mk(O, I, 12'h202, 8'h03, O, 12'h000, O, 3'd2, I, O, 12'h123);
        tbl[8]  = mk(O, I, 12'h203, 8'h04, O, 12'h000, O, 3'd3, I, O, 12'h123);
        tbl[9]  = mk(O, I, 12'h204, 8'h05, O, 12'h000, O, 3'd4, O, O, 12'h123);
        tbl[10] = mk(I, O, 12'h000, 8'h00, O, 12'h000, O, 3'd4, O, O, 12'h123);
        tbl[11] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd4, O, O, 12'h200);
        tbl[12] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd3, I, O, 12'h201);
        tbl[13] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd2, I, O, 12'h202);
        tbl[14] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd1, I, O, 12'h203);
        tbl[15] = mk(I, O, 12'h000, 8'h00, O, 12'h000, O, 3'd0, I, O, 12'h203);
        tbl[16] = mk(O, I, 12'h400, 8'hB1, O, 12'h000, O, 3'd0, I, O, 12'h203);
        tbl[17] = mk(O, I, 12'h401, 8'hB2, O, 12'h000, O, 3'd1, I, O, 12'h203);
        tbl[18] = mk(I, O, 12'h000, 8'h00, I, 12'h010, O, 3'd2, I, O, 12'h010);
        tbl[19] = mk(I, O, 12'h000, 8'h00, I, 12'h011, O, 3'd2, I, O, 12'h011);
        tbl[20] = mk(I, O, 12'h000, 8'h00, I, 12'h012, O, 3'd2, I, I, 12'h012);
        tbl[21] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd2, I, I, 12'h400);
        tbl[22] = mk(I, O, 12'h000, 8'h00, O, 12'h000, I, 3'd1, I, I, 12'h401);
        tbl[23] = mk(I, O, 12'h000, 8'h00, O, 12'h000, O, 3'd0, I, O, 12'h401);

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset fifo_count", 32'(cnt0), 32'(0));
        chk("reset wr_ready", 32'(wr_ready0), 32'(1));
        chk("reset rd_valid", 32'(rd_valid0), 32'(0));
        chk("reset rd_data", 32'(rd_data0), 32'(0));
        chk("reset mem_we", 32'(mwe0), 32'(0));
        chk("reset mem_addr", 32'(maddr0), 32'(0));
        chk("reset mem_wdata", 32'(mwd0), 32'(0));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].bl, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra);
            chk($sformatf("vec%0d mem_we", i), 32'(mwe0), 32'(tbl[i].we));
            chk($sformatf("vec%0d fifo_count", i), 32'(cnt0), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d wr_ready", i), 32'(wr_ready0), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid0), 32'(tbl[i].v));
            chk($sformatf("vec%0d mem_addr", i), 32'(maddr0), 32'(tbl[i].ma));
        end
        chk("first read data", 32'(rd_data0), 32'(8'h12 ^ 8'h5A));

        // reset in the middle of a drain
        drv(O, I, 12'h300, 8'hA1, O, 12'h000);
        drv(O, I, 12'h301, 8'hA2, O, 12'h000);
        drv(O, I, 12'h302, 8'hA3, O, 12'h000);
        drv(I, O, 12'h000, 8'h00, O, 12'h000);
        chk("pre-drain fifo_count", 32'(cnt0), 32'(3));
        drv(I, O, 12'h000, 8'h00, O, 12'h000);
        chk("drain first we", 32'(mwe0), 32'(1));
        chk("drain first addr", 32'(maddr0), 32'(12'h300));
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("no write during reset", 32'(mwe0), 32'(0));
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post-reset fifo_count", 32'(cnt0), 32'(0));
        chk("post-reset wr_ready", 32'(wr_ready0), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post-reset mem_we %0d", i), 32'(mwe0), 32'(0));
            drv(I, O, 12'h000, 8'h00, O, 12'h000);
        end

        // ACTIVE_WR=1 instance drains only in read-free cycles of active video
        e_rd = 8'b0010_1011;
        e_we = 8'b0001_0100;
        e_v  = 8'b1010_1100;
        for (int i = 0; i < 8; i++) begin
            drv(O, i < 2, 12'(12'h500 + i), 8'(8'hC1 + i), e_rd[i], 12'(12'h020 + i));
            chk($sformatf("active_wr step%0d mem_we", i), 32'(mwe1), 32'(e_we[i]));
            chk($sformatf("active_wr step%0d rd_valid", i), 32'(rd_valid1), 32'(e_v[i]));
        end
        chk("active_wr=0 still holding", 32'(cnt0), 32'(2));
        repeat (4) drv(I, O, 12'h000, 8'h00, O, 12'h000);
        chk("hold drained", 32'(cnt0), 32'(0));

        // same-address writes: old value readable before drain, last write wins after
        drv(O, I, 12'h050, 8'h11, O, 12'h000);
        drv(O, I, 12'h050, 8'h22, O, 12'h000);
        drv(O, O, 12'h000, 8'h00, I, 12'h050);
        drv(O, O, 12'h000, 8'h00, O, 12'h000);
        drv(O, O, 12'h000, 8'h00, O, 12'h000);
        chk("stale read valid", 32'(rd_valid0), 32'(1));
        chk("stale read data", 32'(rd_data0), 32'(8'h0A));
        repeat (4) drv(I, O, 12'h000, 8'h00, O, 12'h000);
        chk("u0 last write wins", 32'(ram[0][12'h050]), 32'(8'h22));
        chk("u1 last write wins", 32'(ram[1][12'h050]), 32'(8'h22));

        repeat (3) drv(I, O, 12'h000, 8'h00, O, 12'h000);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d writes outstanding", k), 32'(wq[k].size()), 32'(0));
            chk($sformatf("u%0d reads outstanding", k), 32'(rq[k].size()), 32'(0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
